// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder (two half adders) with registered carry, LSB first.
// Result valid WIDTH cycles after accept; result holds in DONE until out_ready, no accept until retired.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
   logic [CW-1:0]    cnt;
   logic             carry, msb_cin;
   logic             p, g0, s_bit, g1;
   logic             accept, last_bit;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_ready && in_valid;
   assign last_bit  = (cnt == LAST);

   // two half adders form the full adder for the current bit position
   assign p     = a_sh[0] ^ b_sh[0];
   assign g0    = a_sh[0] & b_sh[0];
   assign s_bit = p ^ carry;
   assign g1    = p & carry;

   always_comb begin
      sum_nxt = sum_sh >> 1;
      sum_nxt[WIDTH-1] = s_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         msb_cin <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         sum_sh <= sum_nxt;
         carry  <= g0 | g1;
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         cnt    <= cnt + CW'(1);
         // carry entering the MSB is kept for the signed overflow flag
         if (last_bit) msb_cin <= carry;
      end
   end

   assign sum  = out_valid ? sum_sh : '0;
   assign cout = out_valid ? carry : 1'b0;
   assign ovf  = out_valid ? (msb_cin ^ carry) : 1'b0;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed corners and random adds at WIDTH=8, exhaustive at WIDTH=4.
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel4 = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0, b = '0;
   logic        cin = 1'b0;

   logic       in_ready8, out_valid8, cout8, ovf8;
   logic [7:0] sum8;
   logic       in_ready4, out_valid4, cout4, ovf4;
   logic [3:0] sum4;

   logic        rdy_o, ov_o, cout_o, ovf_o;
   logic [31:0] sum_o;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel4), .in_ready(in_ready8),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(out_valid8), .out_ready(out_ready),
      .sum(sum8), .cout(cout8), .ovf(ovf8));

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel4), .in_ready(in_ready4),
      .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(out_valid4), .out_ready(out_ready),
      .sum(sum4), .cout(cout4), .ovf(ovf4));

   assign rdy_o  = sel4 ? in_ready4  : in_ready8;
   assign ov_o   = sel4 ? out_valid4 : out_valid8;
   assign cout_o = sel4 ? cout4      : cout8;
   assign ovf_o  = sel4 ? ovf4       : ovf8;
   assign sum_o  = sel4 ? 32'(sum4)  : 32'(sum8);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction; called and returning at 1 time unit after a rising edge.
   task automatic op(input bit w4, input logic [31:0] aa, input logic [31:0] bb,
                     input bit ci, input int stall);
      int          w, k;
      logic [31:0] mask, full, es;
      bit          ec, eo;
      string       tag;
      w    = w4 ? 4 : 8;
      mask = (32'd1 << w) - 1;
      aa   = aa & mask;
      bb   = bb & mask;
      full = aa + bb + 32'(ci);
      es   = full & mask;
      ec   = full[w];
      eo   = (aa[w-1] == bb[w-1]) && (es[w-1] != aa[w-1]);
      tag  = $sformatf("w%0d %0h+%0h+%0d", w, aa, bb, ci);
      sel4 = w4;
      #0;
      chk({tag, " ready_before"}, rdy_o, 1);
      a = aa; b = bb; cin = ci; in_valid = 1'b1;
      out_ready = (stall == 0);
      step();
      in_valid = 1'b0;
      a = $urandom; b = $urandom;
      k = 0;
      while (!ov_o && k < 40) begin
         step();
         k++;
      end
      chk({tag, " latency"}, k, w);
      chk({tag, " sum"}, sum_o, es);
      chk({tag, " cout"}, cout_o, ec);
      chk({tag, " ovf"}, ovf_o, eo);
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'($urandom);
         a = $urandom; b = $urandom;
         step();
         chk({tag, " hold_valid"}, ov_o, 1);
         chk({tag, " hold_sum"}, sum_o, es);
         chk({tag, " hold_ready"}, rdy_o, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk({tag, " retire_valid"}, ov_o, 0);
      chk({tag, " retire_sum"}, sum_o, 0);
      chk({tag, " retire_ready"}, rdy_o, 1);
   endtask

   initial begin
      // reset and idle
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", in_ready8, 1);
      chk("rst_valid", out_valid8, 0);
      chk("rst_sum", sum8, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_ready", in_ready8, 1);
         chk("idle_valid", out_valid8, 0);
      end

      // basic adds and carry/overflow corners
      op(0, 32'h00, 32'h00, 0, 0);
      op(0, 32'h3A, 32'h25, 1, 0);
      op(0, 32'hFF, 32'h01, 0, 0);
      op(0, 32'h7F, 32'h01, 0, 0);
      op(0, 32'h80, 32'h80, 0, 0);
      op(0, 32'hFF, 32'hFF, 1, 0);

      // backpressure with toggling inputs
      op(0, 32'h12, 32'h34, 0, 5);
      step();
      chk("bp_no_second_accept", in_ready8, 1);

      // retire and new request together: accept happens one cycle later
      a = 32'h10; b = 32'h20; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("sim_accept1", in_ready8, 0);
      a = 32'h05; b = 32'h06;
      repeat (8) step();
      chk("sim_valid1", out_valid8, 1);
      chk("sim_sum1", sum8, 8'h30);
      step();
      chk("sim_retire_ready", in_ready8, 1);
      chk("sim_retire_valid", out_valid8, 0);
      step();
      chk("sim_accept2", in_ready8, 0);
      in_valid = 1'b0;
      repeat (8) step();
      chk("sim_valid2", out_valid8, 1);
      chk("sim_sum2", sum8, 8'h0B);
      step();
      chk("sim_idle", in_ready8, 1);

      // reset mid-RUN
      a = 32'hAA; b = 32'h55; cin = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk("midrun_busy", in_ready8, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_rst_ready", in_ready8, 1);
      chk("midrun_rst_valid", out_valid8, 0);
      chk("midrun_rst_sum", sum8, 0);
      chk("midrun_rst_cout", cout8, 0);
      step();
      rst_n = 1'b1;
      op(0, 32'h01, 32'h01, 0, 0);

      // reset while holding a result in DONE
      a = 32'hFF; b = 32'h01; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (8) step();
      chk("done_before_rst", out_valid8, 1);
      chk("done_cout_before_rst", cout8, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("done_rst_valid", out_valid8, 0);
      chk("done_rst_sum", sum8, 0);
      chk("done_rst_cout", cout8, 0);
      chk("done_rst_ovf", ovf8, 0);
      chk("done_rst_ready", in_ready8, 1);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();

      // random 8-bit adds
      for (int i = 0; i < 24; i++)
         op(0, $urandom, $urandom, 1'($urandom), $urandom_range(0, 3));

      // exhaustive 4-bit with random stalls
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++)
               op(1, 32'(x), 32'(y), 1'(c), $urandom_range(0, 2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
